// File: rtl/buzzer_sequencer_pkg.sv
// Shared definitions for the buzzer burst sequencer.
// State encodings, board-clock default timings and a sizing helper.
package buzzer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } buz_state_e;

    // 0.5 s on / 0.5 s off at the 50 MHz board clock
    localparam int unsigned DEF_ON_CYCLES  = 25_000_000;
    localparam int unsigned DEF_OFF_CYCLES = 25_000_000;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    localparam int unsigned MAX_BEEPS = 15;

    function automatic int unsigned max_of(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/buzzer_sequencer_sync.sv
// sync_bit: N-flop synchroniser for a single asynchronous bit.
// Ports: clk, rst (async active-low, clears chain), d_in (async), d_out (synced).
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign d_out = chain_q[STAGES-1];

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: gates a resynchronised tone onto the buzzer pad as a
// burst of timed beeps with start/busy/done handshake and stop abort.
// Ports: clk, rst (async active-low), tone_in (async tone), start,
//        beep_count[3:0], stop, buzzer (registered), busy, done (pulse).
module buzzer_sequencer
    import buzzer_sequencer_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES  = DEF_OFF_CYCLES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    input  logic       start,
    input  logic [3:0] beep_count,
    input  logic       stop,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW =
        $clog2(max_of(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

    logic tone_sync;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_tone_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (tone_in),
        .d_out (tone_sync)
    );

    buz_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          buzzer_q, buzzer_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // stop suppresses a same-cycle start, including the
                // zero-length done pulse
                if (start && !stop) begin
                    if (beep_count != 4'd0) begin
                        state_d = ST_ON;
                        rem_d   = beep_count;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (rem_q > 4'd1) begin
                        state_d = ST_OFF;
                        rem_d   = rem_q - 4'd1;
                    end else begin
                        // final beep ends straight into IDLE
                        state_d = ST_IDLE;
                        rem_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OFF: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == OFF_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rem_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Tone follows the registered state; an abort silences it at once.
    always_comb begin
        buzzer_d = tone_sync && (state_q == ST_ON) && !stop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer = buzzer_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed self-checking bench for buzzer_sequencer.
// Short ON/OFF timings, hand-derived cycle-by-cycle expectations.
module tb_buzzer_sequencer;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 3;
    localparam int unsigned SS    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tone_in = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] beep_count = 4'd0;
    logic       buzzer;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    buzzer_sequencer #(
        .ON_CYCLES   (ON_C),
        .OFF_CYCLES  (OFF_C),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .start      (start),
        .beep_count (beep_count),
        .stop       (stop),
        .buzzer     (buzzer),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] bc);
        start      = 1'b1;
        beep_count = bc;
        tick();
        start      = 1'b0;
    endtask

    // Counts buzzer rising edges, busy cycles and done pulses over n edges.
    // Busy count includes the sample taken just before the call.
    task automatic run_count(
        input  int n,
        output int beeps,
        output int busy_cyc,
        output int dones
    );
        logic prev;
        prev     = buzzer;
        beeps    = 0;
        busy_cyc = busy ? 1 : 0;
        dones    = done ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (buzzer && !prev) beeps++;
            prev = buzzer;
            if (busy) busy_cyc++;
            if (done) dones++;
        end
    endtask

    initial begin
        int  beeps;
        int  bcyc;
        int  dones;
        logic prev;
        logic exp_buz;

        // Reset state
        tick();
        tick();
        check("rst buzzer", buzzer, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst     = 1'b1;
        tone_in = 1'b1;
        tick();
        tick();
        tick();
        check("idle busy", busy, 0);

        // 1: three beeps, steady tone
        launch(4'd3);
        check("t1 busy e0", busy, 1);
        check("t1 buz e0", buzzer, 0);
        for (int i = 1; i <= 22; i++) begin
            tick();
            exp_buz = (i >= 1 && i <= 4) || (i >= 8 && i <= 11) ||
                      (i >= 15 && i <= 18);
            check($sformatf("t1 buz %0d", i), buzzer, exp_buz);
            check($sformatf("t1 busy %0d", i), busy, i <= 17);
            check($sformatf("t1 done %0d", i), done, i == 18);
        end

        // 2: zero-length burst
        launch(4'd0);
        check("t2 done", done, 1);
        check("t2 busy", busy, 0);
        check("t2 buz", buzzer, 0);
        tick();
        check("t2 done fall", done, 0);
        check("t2 busy2", busy, 0);

        // 3: toggling tone, one beep; edge 5 takes start
        for (int c = 0; c <= 14; c++) begin
            tone_in    = c[0];
            start      = (c == 5);
            beep_count = 4'd1;
            tick();
            exp_buz = (c >= 6 && c <= 9) ? ((c - 2) % 2 == 1) : 1'b0;
            check($sformatf("t3 buz %0d", c), buzzer, exp_buz);
            check($sformatf("t3 done %0d", c), done, c == 9);
        end
        start   = 1'b0;
        tone_in = 1'b1;
        tick();
        tick();
        tick();

        // 4: stop in second OFF, then a clean single beep
        launch(4'd5);
        for (int i = 1; i <= 11; i++) tick();
        check("t4 pre busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4 stop busy", busy, 0);
        check("t4 stop buz", buzzer, 0);
        check("t4 stop done", done, 0);
        run_count(10, beeps, bcyc, dones);
        check("t4 no done", dones, 0);
        check("t4 idle busy", bcyc, 0);
        launch(4'd1);
        run_count(8, beeps, bcyc, dones);
        check("t4 beeps", beeps, 1);
        check("t4 busy cyc", bcyc, 4);
        check("t4 dones", dones, 1);

        // 5: start while busy is ignored
        launch(4'd2);
        prev  = buzzer;
        beeps = 0;
        bcyc  = busy ? 1 : 0;
        dones = 0;
        for (int i = 1; i <= 16; i++) begin
            start      = (i == 2 || i == 5);
            beep_count = (i == 2 || i == 5) ? 4'd9 : 4'd0;
            tick();
            if (buzzer && !prev) beeps++;
            prev = buzzer;
            if (busy) bcyc++;
            if (done) dones++;
        end
        start = 1'b0;
        check("t5 beeps", beeps, 2);
        check("t5 busy cyc", bcyc, 11);
        check("t5 dones", dones, 1);
        start      = 1'b1;
        stop       = 1'b1;
        beep_count = 4'd3;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5 ss busy", busy, 0);
        check("t5 ss done", done, 0);
        tick();
        check("t5 ss busy2", busy, 0);
        check("t5 ss buz", buzzer, 0);

        // 6: async reset mid-ON
        launch(4'd3);
        tick();
        tick();
        check("t6 pre buz", buzzer, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6 rst buz", buzzer, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst done", done, 0);
        tick();
        rst = 1'b1;
        run_count(3, beeps, bcyc, dones);
        check("t6 post done", dones, 0);
        check("t6 post busy", bcyc, 0);
        launch(4'd1);
        run_count(8, beeps, bcyc, dones);
        check("t6 beeps", beeps, 1);
        check("t6 busy cyc", bcyc, 4);
        check("t6 dones", dones, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
